// File: rtl/reg_scoreboard_pkg.sv
// Shared scoreboard types and constants: register geometry, outstanding-op
// capacity, hazard classification and the destination one-hot decode.
package reg_scoreboard_pkg;

  localparam int unsigned SB_REG_BITS  = 5;
  localparam int unsigned SB_NUM_REGS  = 32;
  localparam int unsigned SB_MAX_OUTST = 4;
  localparam int unsigned SB_CNT_BITS  = $clog2(SB_MAX_OUTST + 1);

  // Reason the ID stage is held; first match wins when several apply
  typedef enum logic [2:0] {
    HZ_NONE,
    HZ_RAW,
    HZ_WAW,
    HZ_LOADUSE,
    HZ_FULL
  } sb_hazard_e;

  function automatic logic [SB_NUM_REGS-1:0] sb_onehot(input logic [SB_REG_BITS-1:0] addr);
    logic [SB_NUM_REGS-1:0] vec;
    vec       = '0;
    vec[addr] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Tracks destinations of in-flight long-latency ops and stalls ID on RAW, WAW,
// load-use and capacity hazards; completions are bypassed into the same cycle.
module reg_scoreboard
  import reg_scoreboard_pkg::*;
#(
  parameter int unsigned REG_BITS  = SB_REG_BITS,
  parameter int unsigned NUM_REGS  = SB_NUM_REGS,
  parameter int unsigned MAX_OUTST = SB_MAX_OUTST,
  localparam int unsigned CNT_BITS = $clog2(MAX_OUTST + 1)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                id_valid_i,
  input  logic [REG_BITS-1:0] id_rs1_addr_i,
  input  logic                id_rs1_use_i,
  input  logic [REG_BITS-1:0] id_rs2_addr_i,
  input  logic                id_rs2_use_i,
  input  logic [REG_BITS-1:0] id_rd_addr_i,
  input  logic                id_reg_wr_i,
  input  logic                id_long_i,
  input  logic                flush_i,
  input  logic                exe_load_i,
  input  logic [REG_BITS-1:0] exe_rd_addr_i,
  input  logic                cpl_valid_i,
  input  logic [REG_BITS-1:0] cpl_rd_addr_i,
  output logic                stall_o,
  output logic                issue_o,
  output logic [NUM_REGS-1:0] pending_o,
  output logic [CNT_BITS-1:0] outst_cnt_o,
  output logic                err_o
);

  logic [NUM_REGS-1:0] pending_q, pending_d, eff_pend;
  logic [CNT_BITS-1:0] cnt_q, cnt_d, eff_cnt;
  logic                err_q, err_d;
  logic                cpl_ok, trk;
  logic                raw_hz, waw_hz, lu_hz, full_hz;
  sb_hazard_e          hazard_cause;

  // Completion bypass: a retiring op frees its register and slot this cycle
  always_comb begin
    cpl_ok   = cpl_valid_i && (cpl_rd_addr_i != '0) && pending_q[cpl_rd_addr_i];
    eff_pend = pending_q;
    if (cpl_ok) eff_pend[cpl_rd_addr_i] = 1'b0;
    eff_cnt  = cnt_q - CNT_BITS'(cpl_ok);
  end

  // Hazard detection against bypassed state and the instruction in EXE
  always_comb begin
    raw_hz  = (id_rs1_use_i && (id_rs1_addr_i != '0) && eff_pend[id_rs1_addr_i]) ||
              (id_rs2_use_i && (id_rs2_addr_i != '0) && eff_pend[id_rs2_addr_i]);
    waw_hz  = id_reg_wr_i && (id_rd_addr_i != '0) && eff_pend[id_rd_addr_i];
    lu_hz   = exe_load_i && (exe_rd_addr_i != '0) &&
              ((id_rs1_use_i && (id_rs1_addr_i == exe_rd_addr_i)) ||
               (id_rs2_use_i && (id_rs2_addr_i == exe_rd_addr_i)));
    full_hz = id_long_i && id_reg_wr_i && (eff_cnt == CNT_BITS'(MAX_OUTST));

    hazard_cause = HZ_NONE;
    if (id_valid_i && !flush_i) begin
      if (raw_hz)       hazard_cause = HZ_RAW;
      else if (waw_hz)  hazard_cause = HZ_WAW;
      else if (lu_hz)   hazard_cause = HZ_LOADUSE;
      else if (full_hz) hazard_cause = HZ_FULL;
    end

    stall_o = (hazard_cause != HZ_NONE);
    issue_o = id_valid_i && !flush_i && !stall_o;
  end

  // Next-state: tracked issues claim a bit and a slot; bad completions latch an error
  always_comb begin
    trk       = issue_o && id_long_i && id_reg_wr_i && (id_rd_addr_i != '0);
    pending_d = eff_pend;
    if (trk) pending_d = eff_pend | NUM_REGS'(sb_onehot(SB_REG_BITS'(id_rd_addr_i)));
    cnt_d     = eff_cnt + CNT_BITS'(trk);
    err_d     = err_q || (cpl_valid_i && !cpl_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  assign pending_o   = pending_q;
  assign outst_cnt_o = cnt_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Scoreboard bench for reg_scoreboard: directed vectors push expected responses,
// a negedge monitor pops and compares them.
module tb_reg_scoreboard;
  import reg_scoreboard_pkg::*;

  localparam int unsigned CW = $clog2(SB_MAX_OUTST + 1);

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        id_valid_i, id_rs1_use_i, id_rs2_use_i, id_reg_wr_i, id_long_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        flush_i, exe_load_i, cpl_valid_i;
  logic [4:0]  exe_rd_addr_i, cpl_rd_addr_i;
  logic        stall_o, issue_o, err_o;
  logic [31:0] pending_o;
  logic [CW-1:0] outst_cnt_o;

  reg_scoreboard dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .id_valid_i(id_valid_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs1_use_i(id_rs1_use_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_rs2_use_i(id_rs2_use_i),
    .id_rd_addr_i(id_rd_addr_i), .id_reg_wr_i(id_reg_wr_i), .id_long_i(id_long_i),
    .flush_i(flush_i), .exe_load_i(exe_load_i), .exe_rd_addr_i(exe_rd_addr_i),
    .cpl_valid_i(cpl_valid_i), .cpl_rd_addr_i(cpl_rd_addr_i),
    .stall_o(stall_o), .issue_o(issue_o), .pending_o(pending_o),
    .outst_cnt_o(outst_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        stall;
    logic        issue;
    logic [31:0] pend;
    logic [CW-1:0] cnt;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;

  task automatic cmp(input string nm, input string field, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, act, exp);
    end
  endtask

  // Monitor: count bound every cycle, plus the queued expectation when one is due
  always @(negedge clk_i) begin
    exp_t e;
    cmp("invariant", "cnt_le_max", 32'(outst_cnt_o <= CW'(SB_MAX_OUTST)), 32'd1);
    if (mon_en) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL monitor: output sampled with empty expectation queue");
      end else begin
        e = exp_q.pop_front();
        cmp(e.name, "stall",   32'(stall_o),     32'(e.stall));
        cmp(e.name, "issue",   32'(issue_o),     32'(e.issue));
        cmp(e.name, "pending", pending_o,        e.pend);
        cmp(e.name, "cnt",     32'(outst_cnt_o), 32'(e.cnt));
        cmp(e.name, "err",     32'(err_o),       32'(e.err));
      end
    end
  end

  task automatic clr();
    id_valid_i = 0; id_rs1_addr_i = 0; id_rs1_use_i = 0; id_rs2_addr_i = 0; id_rs2_use_i = 0;
    id_rd_addr_i = 0; id_reg_wr_i = 0; id_long_i = 0; flush_i = 0;
    exe_load_i = 0; exe_rd_addr_i = 0; cpl_valid_i = 0; cpl_rd_addr_i = 0;
  endtask

  task automatic set_id(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic lng);
    clr();
    id_valid_i = 1; id_rs1_addr_i = rs1; id_rs1_use_i = u1; id_rs2_addr_i = rs2; id_rs2_use_i = u2;
    id_rd_addr_i = rd; id_reg_wr_i = wr; id_long_i = lng;
  endtask

  task automatic cpl(input logic [4:0] rd);
    cpl_valid_i = 1; cpl_rd_addr_i = rd;
  endtask

  // Inputs are already applied; expect values for this cycle, then advance
  task automatic step(input string nm, input logic s, input logic i, input logic [31:0] p,
                      input logic [CW-1:0] c, input logic e);
    exp_t x;
    x.name = nm; x.stall = s; x.issue = i; x.pend = p; x.cnt = c; x.err = e;
    exp_q.push_back(x);
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    step("idle", 0, 0, 32'h0, 0, 0);

    // Build pending={x2,x5}, count=2, plus an illegal completion, then async reset
    set_id(0, 0, 0, 0, 2, 1, 1);       step("rst_iss2", 0, 1, 32'h0, 0, 0);
    set_id(0, 0, 0, 0, 5, 1, 1);       step("rst_iss5", 0, 1, 32'h4, 1, 0);
    clr(); cpl(12);                    step("pre_rst", 0, 0, 32'h24, 2, 0);
    clr(); rst_ni = 1'b0;              step("async_rst", 0, 0, 32'h0, 0, 0);
    rst_ni = 1'b1;                     step("post_rst", 0, 0, 32'h0, 0, 0);

    // Load miss on x5 and a dependent reader
    set_id(0, 0, 0, 0, 5, 1, 1);       step("ld_x5", 0, 1, 32'h0, 0, 0);
    set_id(5, 1, 0, 0, 6, 1, 0);       step("raw_x5_a", 1, 0, 32'h20, 1, 0);
                                       step("raw_x5_b", 1, 0, 32'h20, 1, 0);
    cpl(5);                            step("raw_x5_cpl", 0, 1, 32'h20, 1, 0);
    clr();                             step("x5_clear", 0, 0, 32'h0, 0, 0);

    // Load-use against EXE
    set_id(0, 0, 7, 1, 8, 1, 0); exe_load_i = 1; exe_rd_addr_i = 7; step("lu_rs2", 1, 0, 32'h0, 0, 0);
    set_id(0, 0, 7, 1, 8, 1, 0);       step("lu_gone", 0, 1, 32'h0, 0, 0);
    set_id(0, 0, 7, 0, 8, 1, 0); exe_load_i = 1; exe_rd_addr_i = 7; step("lu_nouse", 0, 1, 32'h0, 0, 0);
    set_id(0, 0, 0, 1, 8, 1, 0); exe_load_i = 1; exe_rd_addr_i = 0; step("lu_x0", 0, 1, 32'h0, 0, 0);
    set_id(7, 1, 0, 0, 8, 1, 0); exe_load_i = 1; exe_rd_addr_i = 7; step("lu_rs1", 1, 0, 32'h0, 0, 0);

    // Capacity
    set_id(0, 0, 0, 0, 1, 1, 1);       step("cap1", 0, 1, 32'h0, 0, 0);
    set_id(0, 0, 0, 0, 2, 1, 1);       step("cap2", 0, 1, 32'h2, 1, 0);
    set_id(0, 0, 0, 0, 3, 1, 1);       step("cap3", 0, 1, 32'h6, 2, 0);
    set_id(0, 0, 0, 0, 4, 1, 1);       step("cap4", 0, 1, 32'hE, 3, 0);
    set_id(0, 0, 0, 0, 9, 1, 1);       step("cap_full", 1, 0, 32'h1E, 4, 0);
    cpl(2);                            step("cap_cpl", 0, 1, 32'h1E, 4, 0);
    clr();                             step("cap_after", 0, 0, 32'h21A, 4, 0);

    // WAW and flush
    set_id(0, 0, 0, 0, 3, 1, 0);       step("waw", 1, 0, 32'h21A, 4, 0);
    flush_i = 1;                       step("flush", 0, 0, 32'h21A, 4, 0);
    clr();                             step("flush_after", 0, 0, 32'h21A, 4, 0);

    // Same-register issue and completion in one cycle, at full capacity
    set_id(0, 0, 0, 0, 3, 1, 1); cpl(3); step("same_reg", 0, 1, 32'h21A, 4, 0);
    clr();                             step("same_reg_after", 0, 0, 32'h21A, 4, 0);

    // Illegal completions
    cpl(12);                           step("err_cpl12", 0, 0, 32'h21A, 4, 0);
    clr(); cpl(0);                     step("err_cpl0", 0, 0, 32'h21A, 4, 1);
    clr();                             step("err_sticky", 0, 0, 32'h21A, 4, 1);

    // Drain, then untracked long ops
    cpl(1);                            step("drain1", 0, 0, 32'h21A, 4, 1);
    clr(); cpl(3);                     step("drain3", 0, 0, 32'h218, 3, 1);
    clr(); cpl(4);                     step("drain4", 0, 0, 32'h210, 2, 1);
    clr(); cpl(9);                     step("drain9", 0, 0, 32'h200, 1, 1);
    set_id(0, 0, 0, 0, 0, 1, 1);       step("long_x0", 0, 1, 32'h0, 0, 1);
    set_id(0, 0, 0, 0, 6, 0, 1);       step("long_nowr", 0, 1, 32'h0, 0, 1);
    clr();                             step("long_after", 0, 0, 32'h0, 0, 1);

    mon_en = 1'b0;
    cmp("end", "queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
